// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared elevator floor types and direction constants
package elevator_pkg;

    localparam int NUM_FLOORS = 4;
    localparam int FLOOR_W    = 2;

    typedef logic [FLOOR_W-1:0] floor_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/floor_request_queue_if.sv
// rtl/floor_request_queue_if.sv - buttons, FSM status and selected-target bundle
interface floor_request_queue_if;
    import elevator_pkg::*;

    logic [NUM_FLOORS-1:0] btn_raw;
    floor_t                cur_floor;
    logic                  dir_up;
    logic                  stop_ack;
    logic [NUM_FLOORS-1:0] pending;
    logic [NUM_FLOORS-1:0] press_pulse;
    floor_t                target_floor;
    logic                  target_valid;
    logic                  target_up;
    logic                  stop_here;

    modport master (
        output btn_raw, cur_floor, dir_up, stop_ack,
        input  pending, press_pulse, target_floor, target_valid, target_up, stop_here
    );

    modport slave (
        input  btn_raw, cur_floor, dir_up, stop_ack,
        output pending, press_pulse, target_floor, target_valid, target_up, stop_here
    );

endinterface

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - 2-FF synchronizer, stability counter and press pulse for one button
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            level       <= 1'b0;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync1       <= btn_raw;
            sync2       <= sync1;
            press_pulse <= 1'b0;
            // Any agreement with the current level restarts the stability window.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level       <= sync2;
                cnt         <= '0;
                press_pulse <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/floor_request_queue.sv
// rtl/floor_request_queue.sv - latches debounced cab presses and picks the next floor by SCAN order
module floor_request_queue
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                         clk,
    input  logic                         reset,
    floor_request_queue_if.slave         bus
);

    logic [NUM_FLOORS-1:0] pulse;
    logic [NUM_FLOORS-1:0] pending_q;
    floor_t                target_floor_q;
    logic                  target_valid_q;
    logic                  target_up_q;
    logic                  stop_here_q;

    logic                  above_found;
    logic                  below_found;
    floor_t                above_floor;
    floor_t                below_floor;
    floor_t                sel_floor;

    for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk         (clk),
            .reset       (reset),
            .btn_raw     (bus.btn_raw[g]),
            .press_pulse (pulse[g])
        );
    end

    // A stop at a floor wins over a press of that same floor: the car is already there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (bus.stop_ack && (bus.cur_floor == floor_t'(i))) begin
                    pending_q[i] <= 1'b0;
                end else if (pulse[i]) begin
                    pending_q[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        above_found = 1'b0;
        above_floor = bus.cur_floor;
        below_found = 1'b0;
        below_floor = bus.cur_floor;
        // Descending scan leaves the closest floor above; ascending leaves the closest below.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending_q[i] && (floor_t'(i) > bus.cur_floor)) begin
                above_found = 1'b1;
                above_floor = floor_t'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_q[i] && (floor_t'(i) < bus.cur_floor)) begin
                below_found = 1'b1;
                below_floor = floor_t'(i);
            end
        end

        sel_floor = target_floor_q;
        unique case (bus.dir_up)
            DIR_UP: begin
                if (above_found)                   sel_floor = above_floor;
                else if (below_found)              sel_floor = below_floor;
                else if (pending_q[bus.cur_floor]) sel_floor = bus.cur_floor;
            end
            DIR_DOWN: begin
                if (below_found)                   sel_floor = below_floor;
                else if (above_found)              sel_floor = above_floor;
                else if (pending_q[bus.cur_floor]) sel_floor = bus.cur_floor;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target_floor_q <= '0;
            target_valid_q <= 1'b0;
            target_up_q    <= 1'b0;
            stop_here_q    <= 1'b0;
        end else begin
            target_floor_q <= sel_floor;
            target_valid_q <= |pending_q;
            target_up_q    <= (sel_floor > bus.cur_floor);
            stop_here_q    <= pending_q[bus.cur_floor];
        end
    end

    assign bus.pending      = pending_q;
    assign bus.press_pulse  = pulse;
    assign bus.target_floor = target_floor_q;
    assign bus.target_valid = target_valid_q;
    assign bus.target_up    = target_up_q;
    assign bus.stop_here    = stop_here_q;

endmodule

// File: tb/tb_floor_request_queue.sv
// tb/tb_floor_request_queue.sv - scoreboard bench for floor_request_queue with DEBOUNCE_CYCLES = 4
module tb_floor_request_queue;
    import elevator_pkg::*;

    localparam int F_PEND   = 0;
    localparam int F_TFLOOR = 1;
    localparam int F_TVALID = 2;
    localparam int F_TUP    = 3;
    localparam int F_STOP   = 4;
    localparam int F_PULSE  = 5;

    typedef struct {
        int         cyc;
        int         field;
        logic [3:0] val;
        string      name;
    } exp_t;

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } pls_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   t0;

    exp_t exp_q[$];
    pls_t pls_q[$];

    floor_request_queue_if bus ();

    floor_request_queue #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [3:0] field_val(int f);
        case (f)
            F_PEND:   return bus.pending;
            F_TFLOOR: return {2'b00, bus.target_floor};
            F_TVALID: return {3'b000, bus.target_valid};
            F_TUP:    return {3'b000, bus.target_up};
            F_STOP:   return {3'b000, bus.stop_here};
            default:  return bus.press_pulse;
        endcase
    endfunction

    task automatic expect_at(input int at, input int field, input logic [3:0] v, input string nm);
        exp_t e;
        e.cyc = at; e.field = field; e.val = v; e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic expect_pulse(input int at, input logic [3:0] v);
        pls_t p;
        p.cyc = at; p.val = v;
        pls_q.push_back(p);
    endtask

    task automatic expect_zero(input int at, input string nm);
        expect_at(at, F_PEND,   4'd0, {nm, "_pending"});
        expect_at(at, F_PULSE,  4'd0, {nm, "_pulse"});
        expect_at(at, F_TFLOOR, 4'd0, {nm, "_tfloor"});
        expect_at(at, F_TVALID, 4'd0, {nm, "_tvalid"});
        expect_at(at, F_TUP,    4'd0, {nm, "_tup"});
        expect_at(at, F_STOP,   4'd0, {nm, "_stop"});
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic serve(input int f);
        bus.cur_floor = floor_t'(f);
        bus.stop_ack  = 1'b1;
        tick(1);
        bus.stop_ack  = 1'b0;
    endtask

    // Scoreboard monitor: compares every due expectation and every observed press pulse.
    always @(negedge clk) begin
        logic [3:0] got;
        for (int k = exp_q.size() - 1; k >= 0; k--) begin
            if (exp_q[k].cyc == cyc) begin
                got = field_val(exp_q[k].field);
                checks++;
                if (got !== exp_q[k].val) begin
                    errors++;
                    $display("FAIL %s cyc %0d: got %b expected %b", exp_q[k].name, cyc, got, exp_q[k].val);
                end
                exp_q.delete(k);
            end
        end
        if (bus.press_pulse !== 4'b0000) begin
            checks++;
            if (pls_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse cyc %0d: got %b expected none", cyc, bus.press_pulse);
            end else begin
                pls_t p;
                p = pls_q.pop_front();
                if ((p.cyc != cyc) || (p.val !== bus.press_pulse)) begin
                    errors++;
                    $display("FAIL press_pulse: got %b at cyc %0d expected %b at cyc %0d",
                             bus.press_pulse, cyc, p.val, p.cyc);
                end
            end
        end
    end

    initial begin
        reset         = 1'b1;
        bus.btn_raw   = 4'b1111;
        bus.cur_floor = 2'd0;
        bus.dir_up    = DIR_UP;
        bus.stop_ack  = 1'b0;

        // Reset with all buttons held, then release and let them latch.
        tick(1);
        expect_zero(cyc + 1, "t1_reset");
        tick(2);
        reset = 1'b0;
        t0 = cyc;
        expect_pulse(t0 + 6, 4'b1111);
        expect_at(t0 + 6, F_PEND,   4'b0000, "t1_pend_early");
        expect_at(t0 + 7, F_PEND,   4'b1111, "t1_pend");
        expect_at(t0 + 8, F_TFLOOR, 4'd1,    "t1_tfloor");
        expect_at(t0 + 8, F_TVALID, 4'd1,    "t1_tvalid");
        expect_at(t0 + 8, F_TUP,    4'd1,    "t1_tup");
        expect_at(t0 + 8, F_STOP,   4'd1,    "t1_stop");
        tick(8);
        bus.btn_raw = 4'b0000;
        tick(8);

        // SCAN direction: pending = 1001 from floor 1.
        serve(1);
        serve(2);
        bus.cur_floor = 2'd1;
        bus.dir_up    = DIR_UP;
        t0 = cyc;
        expect_at(t0 + 1, F_PEND,   4'b1001, "t3_pend");
        expect_at(t0 + 1, F_TFLOOR, 4'd3,    "t3_up_tfloor");
        expect_at(t0 + 1, F_TUP,    4'd1,    "t3_up_tup");
        expect_at(t0 + 1, F_STOP,   4'd0,    "t3_stop");
        tick(1);
        bus.dir_up = DIR_DOWN;
        expect_at(t0 + 2, F_TFLOOR, 4'd0,    "t3_dn_tfloor");
        expect_at(t0 + 2, F_TUP,    4'd0,    "t3_dn_tup");
        expect_at(t0 + 2, F_TVALID, 4'd1,    "t3_dn_tvalid");
        tick(1);

        // Service the last request at floor 3.
        serve(0);
        bus.cur_floor = 2'd3;
        t0 = cyc;
        expect_at(t0 + 1, F_PEND,   4'b1000, "t4_pend");
        expect_at(t0 + 1, F_STOP,   4'd1,    "t4_stop_here");
        expect_at(t0 + 1, F_TFLOOR, 4'd3,    "t4_tfloor");
        expect_at(t0 + 1, F_TVALID, 4'd1,    "t4_tvalid");
        expect_at(t0 + 1, F_TUP,    4'd0,    "t4_tup");
        expect_at(t0 + 2, F_PEND,   4'b0000, "t4_cleared");
        expect_at(t0 + 2, F_TVALID, 4'd1,    "t4_tvalid_lag");
        expect_at(t0 + 3, F_TVALID, 4'd0,    "t4_tvalid_off");
        expect_at(t0 + 3, F_TFLOOR, 4'd3,    "t4_tfloor_hold");
        expect_at(t0 + 3, F_TUP,    4'd0,    "t4_tup_off");
        tick(1);
        serve(3);
        tick(4);

        // Bounce on button 2 for 20 cycles, then a clean hold.
        for (int k = 0; k < 5; k++) begin
            bus.btn_raw = 4'b0100;
            tick(2);
            bus.btn_raw = 4'b0000;
            tick(2);
        end
        bus.btn_raw = 4'b0100;
        t0 = cyc;
        expect_pulse(t0 + 6, 4'b0100);
        expect_at(t0 + 6, F_PEND,   4'b0000, "t2_pend_early");
        expect_at(t0 + 7, F_PEND,   4'b0100, "t2_pend");
        expect_at(t0 + 8, F_TFLOOR, 4'd2,    "t2_tfloor");
        expect_at(t0 + 8, F_TVALID, 4'd1,    "t2_tvalid");
        expect_at(t0 + 8, F_TUP,    4'd0,    "t2_tup");
        tick(9);
        bus.btn_raw = 4'b0000;
        tick(8);

        // Press landing on the same cycle as a stop at that floor.
        serve(2);
        bus.btn_raw = 4'b0100;
        t0 = cyc;
        expect_pulse(t0 + 6, 4'b0100);
        expect_at(t0 + 7, F_PEND, 4'b0000, "t5_clear_wins");
        tick(6);
        bus.stop_ack = 1'b1;
        tick(1);
        bus.stop_ack = 1'b0;
        bus.btn_raw  = 4'b0000;
        tick(8);
        bus.btn_raw = 4'b0100;
        t0 = cyc;
        expect_pulse(t0 + 6, 4'b0100);
        expect_at(t0 + 7, F_PEND, 4'b0100, "t5_other_floor");
        tick(6);
        bus.cur_floor = 2'd1;
        bus.stop_ack  = 1'b1;
        tick(1);
        bus.stop_ack = 1'b0;
        bus.btn_raw  = 4'b0000;
        tick(8);

        // Reset in the middle of debouncing button 0, button kept held.
        bus.btn_raw = 4'b0001;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        expect_zero(cyc, "t6_async");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        t0 = cyc;
        expect_pulse(t0 + 6, 4'b0001);
        expect_at(t0 + 6, F_PEND,   4'b0000, "t6_pend_early");
        expect_at(t0 + 7, F_PEND,   4'b0001, "t6_pend");
        expect_at(t0 + 8, F_TFLOOR, 4'd0,    "t6_tfloor");
        expect_at(t0 + 8, F_TVALID, 4'd1,    "t6_tvalid");
        tick(12);

        foreach (exp_q[k]) begin
            checks++;
            errors++;
            $display("FAIL %s: not observed, expected %b at cyc %0d", exp_q[k].name, exp_q[k].val, exp_q[k].cyc);
        end
        foreach (pls_q[k]) begin
            checks++;
            errors++;
            $display("FAIL missing_pulse: got none expected %b at cyc %0d", pls_q[k].val, pls_q[k].cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
